// File: rtl/game_input_pkg.sv
// Shared key map, button indices and types for the keyboard command decoder.
package game_input_pkg;

  localparam logic [7:0] KEY_P1_LEFT    = 8'h04;
  localparam logic [7:0] KEY_P1_RIGHT   = 8'h07;
  localparam logic [7:0] KEY_P1_JUMP    = 8'h1A;
  localparam logic [7:0] KEY_P1_ATTACK  = 8'h0D;
  localparam logic [7:0] KEY_P1_SPECIAL = 8'h0E;
  localparam logic [7:0] KEY_P2_LEFT    = 8'h50;
  localparam logic [7:0] KEY_P2_RIGHT   = 8'h4F;
  localparam logic [7:0] KEY_P2_JUMP    = 8'h52;
  localparam logic [7:0] KEY_P2_ATTACK  = 8'h59;
  localparam logic [7:0] KEY_P2_SPECIAL = 8'h5A;

  localparam int unsigned BTN_LEFT    = 0;
  localparam int unsigned BTN_RIGHT   = 1;
  localparam int unsigned BTN_JUMP    = 2;
  localparam int unsigned BTN_ATTACK  = 3;
  localparam int unsigned BTN_SPECIAL = 4;

  typedef logic [4:0] btn_vec_t;

  typedef enum logic [1:0] {
    ComboIdle,
    ComboGot1,
    ComboGot2
  } combo_state_e;

  function automatic btn_vec_t btn_mask(input int unsigned idx);
    return btn_vec_t'(1 << idx);
  endfunction

  // Empty slots (8'h00) never match because every mapped code is nonzero.
  function automatic btn_vec_t decode_keys(input logic [47:0] slots,
                                           input logic [7:0]  k_left,
                                           input logic [7:0]  k_right,
                                           input logic [7:0]  k_jump,
                                           input logic [7:0]  k_attack,
                                           input logic [7:0]  k_special);
    btn_vec_t   v;
    logic [7:0] k;
    v = '0;
    for (int s = 0; s < 6; s++) begin
      k = slots[s*8 +: 8];
      v[BTN_LEFT]    = v[BTN_LEFT]    | (k == k_left);
      v[BTN_RIGHT]   = v[BTN_RIGHT]   | (k == k_right);
      v[BTN_JUMP]    = v[BTN_JUMP]    | (k == k_jump);
      v[BTN_ATTACK]  = v[BTN_ATTACK]  | (k == k_attack);
      v[BTN_SPECIAL] = v[BTN_SPECIAL] | (k == k_special);
    end
    return v;
  endfunction

endpackage

// File: rtl/input_decoder_if.sv
// Keycode PIO inputs and per-player command outputs of the input decoder.
interface input_decoder_if;
  import game_input_pkg::*;

  logic        frame_vs;
  logic [15:0] keycode0;
  logic [15:0] keycode1;
  logic [15:0] keycode2;
  logic        ending;
  btn_vec_t    p1_held;
  btn_vec_t    p2_held;
  btn_vec_t    p1_press;
  btn_vec_t    p2_press;
  logic        p1_combo;
  logic        p2_combo;
  logic        frame_tick;

  modport master (
    output frame_vs, keycode0, keycode1, keycode2, ending,
    input  p1_held, p2_held, p1_press, p2_press, p1_combo, p2_combo, frame_tick
  );

  modport slave (
    input  frame_vs, keycode0, keycode1, keycode2, ending,
    output p1_held, p2_held, p1_press, p2_press, p1_combo, p2_combo, frame_tick
  );

endinterface

// File: rtl/combo_fsm.sv
// Three-step press-sequence detector advanced once per frame tick, with a frame window
// between consecutive steps.
module combo_fsm
  import game_input_pkg::*;
#(
  parameter btn_vec_t    Step1       = 5'b00001,
  parameter btn_vec_t    Step2       = 5'b00010,
  parameter btn_vec_t    Step3       = 5'b01000,
  parameter int unsigned ComboWindow = 12
) (
  input  logic     Clk,
  input  logic     Reset_n,
  input  logic     tick_i,
  input  btn_vec_t press_i,
  input  logic     ending_i,
  output logic     combo_o,
  output logic     attack_suppress_o
);

  localparam logic [5:0] WindowCnt = 6'(ComboWindow);

  combo_state_e state_q;
  logic [5:0]   cnt_q;
  logic [5:0]   cnt_inc;
  logic         abandon;

  assign cnt_inc = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;
  assign abandon = (press_i != '0) || (cnt_inc >= WindowCnt);

  // Lets the top drop the final attack bit from press in the same tick the combo fires.
  assign attack_suppress_o = tick_i & ~ending_i & (state_q == ComboGot2) & (press_i == Step3);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ComboIdle;
      cnt_q   <= '0;
      combo_o <= 1'b0;
    end else if (tick_i) begin
      combo_o <= 1'b0;
      if (ending_i) begin
        state_q <= ComboIdle;
        cnt_q   <= '0;
      end else if (press_i == Step1) begin
        // A first step restarts the sequence from any state.
        state_q <= ComboGot1;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ComboGot1: begin
            if (press_i == Step2) begin
              state_q <= ComboGot2;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
              if (abandon) state_q <= ComboIdle;
            end
          end
          ComboGot2: begin
            if (press_i == Step3) begin
              state_q <= ComboIdle;
              cnt_q   <= '0;
              combo_o <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
              if (abandon) state_q <= ComboIdle;
            end
          end
          default: begin
            state_q <= ComboIdle;
            cnt_q   <= cnt_inc;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/input_decoder.sv
// Frame-synchronous keyboard decoder: maps HID keycode slots to per-player held, press and
// combo vectors that update once per vertical-sync falling edge.
module input_decoder
  import game_input_pkg::*;
#(
  parameter int unsigned COMBO_WINDOW = 12
) (
  input logic             Clk,
  input logic             Reset_n,
  input_decoder_if.slave  bus
);

  logic        vs_q;
  logic        vs_valid_q;
  logic        tick;
  logic [47:0] slots;
  btn_vec_t    p1_raw, p2_raw;
  btn_vec_t    p1_prev_q, p2_prev_q;
  btn_vec_t    p1_edge, p2_edge;
  btn_vec_t    p1_held_q, p2_held_q;
  btn_vec_t    p1_press_q, p2_press_q;
  btn_vec_t    p1_press_d, p2_press_d;
  logic        frame_tick_q;
  logic        p1_sup, p2_sup;
  logic        p1_combo, p2_combo;

  // vs_valid_q blocks a tick from frame_vs already low when reset releases.
  assign tick  = vs_valid_q & vs_q & ~bus.frame_vs;
  assign slots = {bus.keycode2, bus.keycode1, bus.keycode0};

  assign p1_raw  = decode_keys(slots, KEY_P1_LEFT, KEY_P1_RIGHT, KEY_P1_JUMP,
                               KEY_P1_ATTACK, KEY_P1_SPECIAL);
  assign p2_raw  = decode_keys(slots, KEY_P2_LEFT, KEY_P2_RIGHT, KEY_P2_JUMP,
                               KEY_P2_ATTACK, KEY_P2_SPECIAL);
  assign p1_edge = p1_raw & ~p1_prev_q;
  assign p2_edge = p2_raw & ~p2_prev_q;

  always_comb begin
    p1_press_d = p1_edge;
    p2_press_d = p2_edge;
    if (p1_sup) p1_press_d[BTN_ATTACK] = 1'b0;
    if (p2_sup) p2_press_d[BTN_ATTACK] = 1'b0;
    if (bus.ending) begin
      p1_press_d = '0;
      p2_press_d = '0;
    end
  end

  combo_fsm #(
    .Step1       (btn_mask(BTN_LEFT)),
    .Step2       (btn_mask(BTN_RIGHT)),
    .Step3       (btn_mask(BTN_ATTACK)),
    .ComboWindow (COMBO_WINDOW)
  ) u_p1_combo (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .tick_i            (tick),
    .press_i           (p1_edge),
    .ending_i          (bus.ending),
    .combo_o           (p1_combo),
    .attack_suppress_o (p1_sup)
  );

  combo_fsm #(
    .Step1       (btn_mask(BTN_RIGHT)),
    .Step2       (btn_mask(BTN_LEFT)),
    .Step3       (btn_mask(BTN_ATTACK)),
    .ComboWindow (COMBO_WINDOW)
  ) u_p2_combo (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .tick_i            (tick),
    .press_i           (p2_edge),
    .ending_i          (bus.ending),
    .combo_o           (p2_combo),
    .attack_suppress_o (p2_sup)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q         <= 1'b1;
      vs_valid_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      p1_prev_q    <= '0;
      p2_prev_q    <= '0;
      p1_held_q    <= '0;
      p2_held_q    <= '0;
      p1_press_q   <= '0;
      p2_press_q   <= '0;
    end else begin
      vs_q         <= bus.frame_vs;
      vs_valid_q   <= 1'b1;
      frame_tick_q <= tick;
      if (tick) begin
        // held_prev keeps tracking through ending so released-ending keys give no press.
        p1_prev_q  <= p1_raw;
        p2_prev_q  <= p2_raw;
        p1_held_q  <= bus.ending ? '0 : p1_raw;
        p2_held_q  <= bus.ending ? '0 : p2_raw;
        p1_press_q <= p1_press_d;
        p2_press_q <= p2_press_d;
      end
    end
  end

  assign bus.p1_held    = p1_held_q;
  assign bus.p2_held    = p2_held_q;
  assign bus.p1_press   = p1_press_q;
  assign bus.p2_press   = p2_press_q;
  assign bus.p1_combo   = p1_combo;
  assign bus.p2_combo   = p2_combo;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_input_decoder.sv
// Scoreboard bench for input_decoder: frame stimulus pushes model expectations, a monitor
// compares them whenever frame_tick is seen.
module tb_input_decoder;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_decoder_if bus ();

  input_decoder #(
    .COMBO_WINDOW (W)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_W = 8'h1A, K_J = 8'h0D, K_K = 8'h0E;
  localparam logic [7:0] K_L = 8'h50, K_R = 8'h4F, K_U = 8'h52, K_1 = 8'h59, K_2 = 8'h5A;

  logic [7:0] codes [2][5];
  logic [4:0] step  [2][3];
  logic [7:0] pool  [12];

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] exp_q[$];

  // Model state: last held vector and the two most recent nonzero press events per player.
  logic [4:0] m_prev   [2];
  logic [4:0] last_vec [2];
  logic [4:0] prev_vec [2];
  int         last_idx [2];
  int         prev_idx [2];
  int         t_idx;

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] dut_out();
    return {bus.p1_held, bus.p2_held, bus.p1_press, bus.p2_press, bus.p1_combo, bus.p2_combo};
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_prev[p]   = '0;
      last_vec[p] = '0;
      prev_vec[p] = '0;
      last_idx[p] = 0;
      prev_idx[p] = 0;
    end
    t_idx = 1000;
  endfunction

  function automatic void push_event(input int p, input logic [4:0] v);
    prev_vec[p] = last_vec[p];
    prev_idx[p] = last_idx[p];
    last_vec[p] = v;
    last_idx[p] = t_idx;
  endfunction

  function automatic logic [21:0] model_frame(input logic [15:0] k0, input logic [15:0] k1,
                                              input logic [15:0] k2, input logic en);
    logic [7:0] slots [6];
    logic [4:0] raw, pr;
    logic [4:0] held [2];
    logic [4:0] press [2];
    logic       combo [2];
    slots = '{k0[7:0], k0[15:8], k1[7:0], k1[15:8], k2[7:0], k2[15:8]};
    for (int p = 0; p < 2; p++) begin
      raw = '0;
      for (int b = 0; b < 5; b++)
        for (int s = 0; s < 6; s++)
          if (slots[s] == codes[p][b]) raw[b] = 1'b1;
      pr = raw & ~m_prev[p];
      m_prev[p] = raw;
      if (en) begin
        held[p] = '0; press[p] = '0; combo[p] = 1'b0;
        push_event(p, 5'b11111);
      end else begin
        combo[p] = (pr == step[p][2]) && (last_vec[p] == step[p][1]) &&
                   (t_idx - last_idx[p] <= W) && (prev_vec[p] == step[p][0]) &&
                   (last_idx[p] - prev_idx[p] <= W);
        held[p]  = raw;
        press[p] = combo[p] ? (pr & 5'b10111) : pr;
        if (pr != '0) push_event(p, pr);
      end
    end
    t_idx++;
    return {held[0], held[1], press[0], press[1], combo[0], combo[1]};
  endfunction

  task automatic frame(input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2,
                       input logic en);
    @(negedge clk);
    bus.keycode0 = k0; bus.keycode1 = k1; bus.keycode2 = k2;
    bus.ending = en; bus.frame_vs = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(model_frame(k0, k1, k2, en));
    bus.frame_vs = 1'b0;
    @(negedge clk);
    // Mid-frame keycode noise must not reach the outputs.
    bus.keycode0 = 16'($urandom); bus.keycode1 = 16'($urandom);
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL tick_missing: got no frame_tick, expected one pending=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic f1(input logic [7:0] a, input logic [7:0] b);
    frame({b, a}, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) f1(8'h00, 8'h00);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.frame_tick) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_tick: got frame_tick=1 expected 0 at %0t", $time);
      end else begin
        check("frame_outputs", dut_out(), exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] pick_code();
    int r;
    r = $urandom_range(0, 23);
    return (r < 12) ? pool[r] : 8'h00;
  endfunction

  initial begin
    codes[0] = '{K_A, K_D, K_W, K_J, K_K};
    codes[1] = '{K_L, K_R, K_U, K_1, K_2};
    step[0]  = '{5'b00001, 5'b00010, 5'b01000};
    step[1]  = '{5'b00010, 5'b00001, 5'b01000};
    pool     = '{K_A, K_D, K_W, K_J, K_K, K_L, K_R, K_U, K_1, K_2, 8'h05, 8'hE0};
    bus.keycode0 = '0; bus.keycode1 = '0; bus.keycode2 = '0;
    bus.ending = 1'b0; bus.frame_vs = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {dut_out()}, 22'h0);
    check("reset_tick", {21'h0, bus.frame_tick}, 22'h0);
    rst_n = 1'b1;

    // Held A across two frames, then A and left-arrow in one word.
    f1(K_A, 8'h00); f1(K_A, 8'h00); idle(1);
    frame(16'h5004, 16'h0, 16'h0, 1'b0); idle(1);

    // P1 combo in frames 1, 3, 5.
    f1(K_A, 8'h00); idle(1); f1(K_D, 8'h00); idle(1); f1(K_J, 8'h00);
    check("combo_direct", {20'h0, bus.p1_combo, bus.p1_press[3]}, 22'b10);
    idle(1);

    // Window boundary: gap of W frames completes, gap of W+1 does not.
    f1(K_A, 8'h00); idle(1); f1(K_D, 8'h00); idle(W - 1); f1(K_J, 8'h00);
    check("window_edge", {20'h0, bus.p1_combo, bus.p1_press[3]}, 22'b10);
    idle(1);
    f1(K_A, 8'h00); idle(1); f1(K_D, 8'h00); idle(W); f1(K_J, 8'h00);
    check("window_late", {15'h0, bus.p1_combo, 1'b0, bus.p1_press}, {15'h0, 2'b00, 5'b01000});
    idle(1);

    // Two-key press breaks the sequence.
    f1(K_A, 8'h00); idle(1); frame({K_W, K_D}, 16'h0, 16'h0, 1'b0); idle(1); f1(K_J, 8'h00);
    idle(1);

    // P2 combo: right, left, attack.
    f1(K_R, 8'h00); f1(8'h00, 8'h00); f1(K_L, 8'h00); f1(K_1, 8'h00);
    check("p2_combo_direct", {20'h0, bus.p2_combo, bus.p2_press[3]}, 22'b10);
    idle(1);

    // Ending with W held throughout.
    f1(K_W, 8'h00);
    for (int i = 0; i < 3; i++) frame({8'h00, K_W}, 16'h0, 16'h0, 1'b1);
    f1(K_W, 8'h00); f1(K_W, 8'h00); idle(1);

    // Reset asserted mid-frame.
    f1(K_A, K_L); f1(K_A, K_L);
    @(negedge clk); bus.frame_vs = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("reset_midframe", dut_out(), 22'h0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    f1(K_A, K_L); idle(1);

    // frame_vs low across reset release yields no tick.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); bus.frame_vs = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.frame_tick) seen++;
      end
      check("no_tick_after_reset", 22'(seen), 22'h0);
    end

    // Randomized frames: single-key taps and arbitrary slot fills.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] s [6];
      logic en;
      en = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < 6; i++) s[i] = 8'h00;
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 6; i++) s[i] = pick_code();
      end else if ($urandom_range(0, 1) == 0) begin
        s[$urandom_range(0, 5)] = pool[$urandom_range(0, 9)];
      end
      frame({s[1], s[0]}, {s[3], s[2]}, {s[5], s[4]}, en);
    end

    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
